// File: rtl/seq_divider.sv
// Multi-cycle unsigned radix-2 restoring divider with a start/done handshake.
// Each CALC cycle does one shift and one trial subtraction (a + ~b + 1, borrow from the carry-out).
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;

    // The restored remainder is always below D, so only its low WIDTH bits are kept;
    // the shifted value needs the full WIDTH+1 bits when D has its MSB set.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] trial;
    logic             no_borrow;
    logic [WIDTH-1:0] q_iter;
    logic [WIDTH-1:0] r_iter;

    assign r_shift  = {r_reg, q_reg[WIDTH-1]};
    assign sub_b    = ~{1'b0, d_reg};
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sub
            assign trial[gi]   = r_shift[gi] ^ sub_b[gi] ^ carry[gi];
            assign carry[gi+1] = (r_shift[gi] & sub_b[gi]) | (carry[gi] & (r_shift[gi] ^ sub_b[gi]));
        end
    endgenerate

    // Top bit of ~{0,D} is always 1, so the carry-out reduces to an OR.
    assign no_borrow = r_shift[WIDTH] | carry[WIDTH];
    assign q_iter    = {q_reg[WIDTH-2:0], no_borrow};
    assign r_iter    = no_borrow ? trial : r_shift[WIDTH-1:0];

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        q_next         = q_reg;
        r_next         = r_reg;
        d_next         = d_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_next     = dividend;
                        r_next     = '0;
                        cnt_next   = '0;
                        d_next     = divisor;
                        state_next = CALC;
                    end else begin
                        quotient_next  = '1;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                        state_next     = DONE;
                    end
                end
            end
            CALC: begin
                q_next   = q_iter;
                r_next   = r_iter;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    quotient_next  = q_iter;
                    remainder_next = r_iter;
                    dbz_next       = 1'b0;
                    state_next     = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            q_reg         <= '0;
            r_reg         <= '0;
            d_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            q_reg         <= q_next;
            r_reg         <= r_next;
            d_reg         <= d_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed 8-bit scenarios plus randomized 32-bit divisions
// checked against plain '/' and '%' arithmetic.
`timescale 1ns/1ps
module tb_seq_divider;

    logic clk;
    int   total;
    int   bad;

    // 8-bit instance
    logic       reset8, start8, busy8, done8, dbz8;
    logic [7:0] dividend8, divisor8, quotient8, remainder8;

    // 32-bit instance
    logic        reset32, start32, busy32, done32, dbz32;
    logic [31:0] dividend32, divisor32, quotient32, remainder32;

    seq_divider #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset8), .start(start8),
        .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8),
        .quotient(quotient8), .remainder(remainder8), .div_by_zero(dbz8)
    );

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .reset(reset32), .start(start32),
        .dividend(dividend32), .divisor(divisor32),
        .busy(busy32), .done(done32),
        .quotient(quotient32), .remainder(remainder32), .div_by_zero(dbz32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one 8-bit division from an IDLE cycle (called at #1 after an edge).
    // k = edges after the accepting edge until done is seen; bcnt = busy cycles;
    // dw = done or busy still high in the cycle after done.
    task automatic div8(input logic [7:0] a, input logic [7:0] b, output int k, output int bcnt,
                        output logic [7:0] q, output logic [7:0] r, output logic z, output logic dw);
        dividend8 = a;
        divisor8  = b;
        start8    = 1'b1;
        @(posedge clk); #1;
        start8     = 1'b0;
        dividend8  = 8'($urandom);
        divisor8   = 8'($urandom);
        k    = 0;
        bcnt = 0;
        while (!done8 && k < 100) begin
            if (busy8) bcnt++;
            @(posedge clk); #1;
            k++;
        end
        if (busy8) bcnt++;
        q = quotient8;
        r = remainder8;
        z = dbz8;
        @(posedge clk); #1;
        dw = done8 | busy8;
        $display("div8  %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d", a, b, q, r, z, k, bcnt);
    endtask

    task automatic div32(input logic [31:0] a, input logic [31:0] b, output int k, output int bcnt,
                         output logic [31:0] q, output logic [31:0] r, output logic z, output logic dw);
        dividend32 = a;
        divisor32  = b;
        start32    = 1'b1;
        @(posedge clk); #1;
        start32    = 1'b0;
        dividend32 = $urandom;
        divisor32  = $urandom;
        k    = 0;
        bcnt = 0;
        while (!done32 && k < 200) begin
            if (busy32) bcnt++;
            @(posedge clk); #1;
            k++;
        end
        if (busy32) bcnt++;
        q = quotient32;
        r = remainder32;
        z = dbz32;
        @(posedge clk); #1;
        dw = done32 | busy32;
        $display("div32 %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d", a, b, q, r, z, k, bcnt);
    endtask

    task automatic test_reset();
        total++;
        if ({busy8, done8, quotient8, remainder8, dbz8} !== 19'd0) begin
            bad++;
            $display("FAIL reset8 outputs got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
                     busy8, done8, quotient8, remainder8, dbz8);
        end
        total++;
        if ({busy32, done32, quotient32, remainder32, dbz32} !== 67'd0) begin
            bad++;
            $display("FAIL reset32 outputs got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
                     busy32, done32, quotient32, remainder32, dbz32);
        end
    endtask

    task automatic test_edge_values();
        logic [7:0] ta [6];
        logic [7:0] tb [6];
        logic [7:0] eq [6];
        logic [7:0] er [6];
        int k, bcnt;
        logic [7:0] q, r;
        logic z, dw;
        ta = '{8'd100, 8'd255, 8'd5, 8'd255, 8'd0, 8'd200};
        tb = '{8'd7,   8'd1,   8'd9, 8'd128, 8'd3, 8'd255};
        eq = '{8'd14,  8'd255, 8'd0, 8'd1,   8'd0, 8'd0};
        er = '{8'd2,   8'd0,   8'd5, 8'd127, 8'd0, 8'd200};
        for (int i = 0; i < 6; i++) begin
            div8(ta[i], tb[i], k, bcnt, q, r, z, dw);
            total++;
            if (q !== eq[i] || r !== er[i] || z !== 1'b0) begin
                bad++;
                $display("FAIL edge %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0",
                         ta[i], tb[i], q, r, z, eq[i], er[i]);
            end
            total++;
            if (k !== 8 || bcnt !== 9 || dw !== 1'b0) begin
                bad++;
                $display("FAIL edge_timing %0d/%0d got lat=%0d busy=%0d after=%b want lat=8 busy=9 after=0",
                         ta[i], tb[i], k, bcnt, dw);
            end
        end
    endtask

    task automatic test_div_zero();
        int k, bcnt;
        logic [7:0] q, r;
        logic z, dw;
        div8(8'd77, 8'd0, k, bcnt, q, r, z, dw);
        total++;
        if (q !== 8'hFF || r !== 8'd77 || z !== 1'b1) begin
            bad++;
            $display("FAIL div_zero got q=%0h r=%0d dbz=%b want q=ff r=77 dbz=1", q, r, z);
        end
        total++;
        if (k !== 0 || bcnt !== 1 || dw !== 1'b0) begin
            bad++;
            $display("FAIL div_zero_timing got lat=%0d busy=%0d after=%b want lat=0 busy=1 after=0", k, bcnt, dw);
        end
        div8(8'd9, 8'd3, k, bcnt, q, r, z, dw);
        total++;
        if (q !== 8'd3 || r !== 8'd0 || z !== 1'b0) begin
            bad++;
            $display("FAIL after_zero got q=%0d r=%0d dbz=%b want q=3 r=0 dbz=0", q, r, z);
        end
    endtask

    task automatic test_start_while_busy();
        int k;
        dividend8 = 8'd100;
        divisor8  = 8'd7;
        start8    = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start8    = 1'b1;
        dividend8 = 8'd50;
        divisor8  = 8'd5;
        k = 2;
        while (!done8 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        $display("busy  100 / 7 with start held -> q=%0d r=%0d lat=%0d", quotient8, remainder8, k);
        total++;
        if (quotient8 !== 8'd14 || remainder8 !== 8'd2 || k !== 8) begin
            bad++;
            $display("FAIL inflight got q=%0d r=%0d lat=%0d want q=14 r=2 lat=8", quotient8, remainder8, k);
        end
        @(posedge clk); #1;
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL idle_gap got busy=%b done=%b want busy=0 done=0", busy8, done8);
        end
        @(posedge clk); #1;
        start8    = 1'b0;
        dividend8 = 8'd1;
        divisor8  = 8'd1;
        total++;
        if (busy8 !== 1'b1 || quotient8 !== 8'd14) begin
            bad++;
            $display("FAIL retrigger got busy=%b q=%0d want busy=1 q=14 (held)", busy8, quotient8);
        end
        k = 0;
        while (!done8 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        $display("busy  50 / 5 retriggered -> q=%0d r=%0d lat=%0d", quotient8, remainder8, k);
        total++;
        if (quotient8 !== 8'd10 || remainder8 !== 8'd0 || dbz8 !== 1'b0 || k !== 8) begin
            bad++;
            $display("FAIL held_start got q=%0d r=%0d dbz=%b lat=%0d want q=10 r=0 dbz=0 lat=8",
                     quotient8, remainder8, dbz8, k);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int k, bcnt;
        logic [7:0] q, r;
        logic z, dw;
        dividend8 = 8'd100;
        divisor8  = 8'd7;
        start8    = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset8 = 1'b1;
        #1;
        $display("reset mid-calc -> busy=%b done=%b q=%0d r=%0d dbz=%b", busy8, done8, quotient8, remainder8, dbz8);
        total++;
        if ({busy8, done8, quotient8, remainder8, dbz8} !== 19'd0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
                     busy8, done8, quotient8, remainder8, dbz8);
        end
        @(posedge clk); #1;
        @(posedge clk); #4;
        reset8 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || quotient8 !== 8'd0) begin
            bad++;
            $display("FAIL post_reset got busy=%b done=%b q=%0d want 0 0 0", busy8, done8, quotient8);
        end
        div8(8'd200, 8'd13, k, bcnt, q, r, z, dw);
        total++;
        if (q !== 8'd15 || r !== 8'd5 || z !== 1'b0 || k !== 8 || bcnt !== 9) begin
            bad++;
            $display("FAIL after_reset got q=%0d r=%0d dbz=%b lat=%0d busy=%0d want 15 5 0 8 9", q, r, z, k, bcnt);
        end
    endtask

    task automatic test_random32();
        int k, bcnt;
        logic [31:0] a, b, q, r, eq, er;
        logic z, ez, dw;
        logic [63:0] recon;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = $urandom_range(1, 255);
                3:       b = $urandom | 32'h8000_0000;
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            if (b == 32'd0) begin
                eq = 32'hFFFF_FFFF;
                er = a;
                ez = 1'b1;
            end else begin
                eq = a / b;
                er = a % b;
                ez = 1'b0;
            end
            div32(a, b, k, bcnt, q, r, z, dw);
            total++;
            if (q !== eq || r !== er || z !== ez) begin
                bad++;
                $display("FAIL rand %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", a, b, q, r, z, eq, er, ez);
            end
            total++;
            if (k !== (ez ? 0 : 32) || bcnt !== (ez ? 1 : 33) || dw !== 1'b0) begin
                bad++;
                $display("FAIL rand_timing %0d/%0d got lat=%0d busy=%0d after=%b want lat=%0d busy=%0d after=0",
                         a, b, k, bcnt, dw, ez ? 0 : 32, ez ? 1 : 33);
            end
            if (b != 32'd0) begin
                recon = 64'(q) * 64'(b) + 64'(r);
                total++;
                if (recon !== 64'(a) || r >= b) begin
                    bad++;
                    $display("FAIL invariant %0d/%0d got q*d+r=%0d r=%0d want %0d with r<d", a, b, recon, r, a);
                end
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset8     = 1'b1;
        reset32    = 1'b1;
        start8     = 1'b0;
        start32    = 1'b0;
        dividend8  = '0;
        divisor8   = '0;
        dividend32 = '0;
        divisor32  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset8  = 1'b0;
        reset32 = 1'b0;
        @(posedge clk); #1;
        test_edge_values();
        test_div_zero();
        test_start_while_busy();
        test_async_reset();
        test_random32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
